sipo_rx: RTL and testbench
==========================

Name: sipo_rx

Overview:
- Serial-in/parallel-out receiver; the far end of the serial link driven by the team's PISO shifter.
- Recovers WIDTH-bit words from S_I using the same S_L framing strobe: S_L=0 marks the load/frame-boundary cycle, S_L=1 marks a shift cycle.
- Presents each completed word on a registered holding register with a valid/ready handshake toward downstream logic.

Parameters:
- WIDTH, 4, word length in data bits (2..32).
- MSB_FIRST, 1, 1 = first received bit lands in P_O[WIDTH-1]; 0 = first bit lands in P_O[0].

Ports:
- clk  input  1  rising-edge clock, shared with the PISO.
- rst_n  input  1  asynchronous, active-low reset.
- S_I  input  1  serial data, sampled on clk rising edge when S_L=1.
- S_L  input  1  framing strobe: 0 = frame boundary (no capture), 1 = shift/capture.
- P_O  output  WIDTH  received word, held stable while P_VALID=1.
- P_VALID  output  1  holding register contains an unconsumed word.
- P_READY  input  1  downstream accepts the word on an edge where P_VALID=1.
- OVERRUN  output  1  one-cycle pulse: a word completed while the holding register was full, so that word is dropped.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bit count=0, shift register=0, P_O=0, P_VALID=0, OVERRUN=0. Deasserting reset mid-frame discards the partial word; the receiver needs a fresh S_L=0 before capturing.
- Bit count is $clog2(WIDTH+1) bits wide and never exceeds WIDTH.
- State machine, evaluated on each clk rising edge:
  - IDLE: S_L=0 moves to SHIFT and clears the count. S_L=1 is ignored, because the frame is not aligned.
  - SHIFT, S_L=0: count clears, the partial word is discarded, and the state stays SHIFT (re-sync).
  - SHIFT, S_L=1: captures S_I into the shift register at the position set by MSB_FIRST, then increments the count.
  - SHIFT, S_L=1 on the capture that makes the count equal WIDTH: the word is complete, and the state goes to IDLE (or PARITY when the feature is enabled). Any further S_L=1 cycles are ignored until the next S_L=0.
- Latency: P_O and P_VALID update on the same edge that samples the last data bit, so they are visible in the following cycle.
- Handshake:
  - An edge with P_VALID=1 and P_READY=1 consumes the word, and P_VALID clears.
  - If a word completes on that same edge, P_O loads the new word and P_VALID stays 1. No bubble and no overrun.
  - A word completing while P_VALID=1 and P_READY=0 leaves P_O unchanged, drops the new word, and pulses OVERRUN for exactly one cycle.
- P_READY while P_VALID=0 has no effect.
- P_O holds its last value after consumption; it is not cleared.
- OVERRUN is 0 at all other times.

Optional Feature:
- Macro: SIPO_RX_PARITY_EN.
- Defined:
  - After WIDTH data bits the FSM enters PARITY. The next S_L=1 edge samples the parity bit; S_L=0 in PARITY aborts to SHIFT with the count cleared.
  - The word completes on the parity-sample edge (latency +1 edge). The completion and overrun rules above are unchanged.
  - Adds output P_ERR (1 bit), registered alongside P_O: P_ERR=1 when the XOR of the WIDTH data bits and the parity bit is 1 (even parity expected).
  - P_ERR resets to 0 and is valid whenever P_VALID=1.
- Undefined: no PARITY state and no P_ERR port.

Decomposition:
- Shared package sipo_pkg:
  - State encoding enum: IDLE, SHIFT, PARITY.
  - Function for the count width: $clog2(WIDTH+1).
- One natural sub-module, sipo_hold_reg: the P_O/P_VALID holding register with the ready/overrun logic.
- The top level contains the FSM, bit counter and shift register.

Test Plan:
- WIDTH=4, MSB_FIRST=1: S_L=0 for one cycle, then S_L=1 with S_I=0,1,0,1 -> P_O=4'b0101, P_VALID=1 from the cycle after the 4th shift edge. P_READY=1 for one edge -> P_VALID=0.
- Back-to-back frames 0101 then 0110 (S_L=0 between them), P_READY tied 1 -> two words accepted in order (4'b0101, 4'b0110); OVERRUN is never asserted.
- P_READY=0 and frames 0101 then 0110 -> P_O stays 4'b0101, OVERRUN pulses for one cycle on completion of 0110. Raising P_READY then consumes 4'b0101 only.
- S_L=0 after 2 shifts (bits 1,1), then a full 0110 frame -> P_O=4'b0110 (partial discarded). S_L=1 with no prior S_L=0 after reset -> no capture, P_VALID stays 0.
- Assert rst_n=0 asynchronously mid-frame and mid-P_VALID -> P_O=0, P_VALID=0 immediately. Next S_L=0 plus 1,0,1,1 -> P_O=4'b1011. With MSB_FIRST=0, the same stream -> P_O=4'b1101.
- SIPO_RX_PARITY_EN defined: frame 0101 + parity 0 -> P_ERR=0; frame 0101 + parity 1 -> P_ERR=1. P_VALID rises one edge later than in non-parity mode.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the sipo_rx serial receiver: FSM state encoding and
// the bit-count width helper.
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } sipo_state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Output holding register for sipo_rx: P_O/P_VALID with ready handshake and
// overrun pulse. Optional P_ERR storage under SIPO_RX_PARITY_EN.
module sipo_hold_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_valid,
  input  logic [WIDTH-1:0] word,
`ifdef SIPO_RX_PARITY_EN
  input  logic             word_err,
  output logic             p_err,
`endif
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic             overrun_r;
`ifdef SIPO_RX_PARITY_EN
  logic             err_r;
`endif

  // Load a completed word when the register is free or being drained, else drop it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r    <= {WIDTH{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
      err_r     <= 1'b0;
`endif
    end else if (word_valid) begin
      if (!valid_r || ready) begin
        data_r    <= word;
        valid_r   <= 1'b1;
        overrun_r <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
        err_r     <= word_err;
`endif
      end else begin
        overrun_r <= 1'b1;
      end
    end else begin
      overrun_r <= 1'b0;
      if (valid_r && ready) begin
        valid_r <= 1'b0;
      end else begin
        valid_r <= valid_r;
      end
    end
  end

  assign data    = data_r;
  assign valid   = valid_r;
  assign overrun = overrun_r;
`ifdef SIPO_RX_PARITY_EN
  assign p_err   = err_r;
`endif

endmodule

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver framed by S_L (0 = boundary, 1 = shift).
// Optional even-parity bit and P_ERR output enabled by SIPO_RX_PARITY_EN.
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S_I,
  input  logic             S_L,
  output logic [WIDTH-1:0] P_O,
  output logic             P_VALID,
  input  logic             P_READY,
`ifdef SIPO_RX_PARITY_EN
  output logic             P_ERR,
`endif
  output logic             OVERRUN
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sipo_state_e      state_r, state_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic [WIDTH-1:0] shift_r, shift_n;
  logic [WIDTH-1:0] shift_cap_s;
  logic [WIDTH-1:0] word_s;
  logic             done_s;
`ifdef SIPO_RX_PARITY_EN
  logic             err_s;
`endif

  // Shift register with the new bit inserted at the end selected by MSB_FIRST.
  always_comb begin
    if (MSB_FIRST) begin
      shift_cap_s = {shift_r[WIDTH-2:0], S_I};
    end else begin
      shift_cap_s = {S_I, shift_r[WIDTH-1:1]};
    end
  end

  // State, count and shift register registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      shift_r <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      shift_r <= shift_n;
    end
  end

  // Framing FSM: align on S_L=0, capture WIDTH bits, then flag the word complete.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    shift_n = shift_r;
    done_s  = 1'b0;
    word_s  = shift_cap_s;
`ifdef SIPO_RX_PARITY_EN
    err_s   = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (!S_L) begin
          state_n = SHIFT;
          cnt_n   = {CW{1'b0}};
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT: begin
        if (!S_L) begin
          cnt_n   = {CW{1'b0}};
          shift_n = {WIDTH{1'b0}};
        end else begin
          shift_n = shift_cap_s;
          cnt_n   = cnt_r + CW'(1);
          if (cnt_r == CNT_LAST) begin
`ifdef SIPO_RX_PARITY_EN
            state_n = PARITY;
`else
            done_s  = 1'b1;
            state_n = IDLE;
`endif
          end else begin
            state_n = SHIFT;
          end
        end
      end
      PARITY: begin
        if (!S_L) begin
          state_n = SHIFT;
          cnt_n   = {CW{1'b0}};
          shift_n = {WIDTH{1'b0}};
        end else begin
          // Data bits are already complete in shift_r; this edge only samples parity.
          done_s  = 1'b1;
          word_s  = shift_r;
`ifdef SIPO_RX_PARITY_EN
          err_s   = (^shift_r) ^ S_I;
`endif
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = {CW{1'b0}};
      end
    endcase
  end

  sipo_hold_reg #(
    .WIDTH (WIDTH)
  ) u_hold (
    .clk        (clk),
    .rst_n      (rst_n),
    .word_valid (done_s),
    .word       (word_s),
`ifdef SIPO_RX_PARITY_EN
    .word_err   (err_s),
    .p_err      (P_ERR),
`endif
    .ready      (P_READY),
    .data       (P_O),
    .valid      (P_VALID),
    .overrun    (OVERRUN)
  );

endmodule

// File: tb/tb_sipo_rx.sv
// Self-checking bench for sipo_rx: MSB-first and LSB-first instances on one
// serial stream, checked every cycle against a queue-based frame model.
module tb_sipo_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_i = 1'b0;
  logic         s_l = 1'b0;
  logic         p_ready = 1'b0;
  logic [W-1:0] po_m, po_l;
  logic         pv_m, pv_l, ovr_m, ovr_l;
`ifdef SIPO_RX_PARITY_EN
  logic         perr_m, perr_l;
`endif

  int compared = 0;
  int mismatched = 0;

  // Reference model state
  bit           aligned;
  bit           wait_par;
  int           q[$];
  logic [W-1:0] exp_po_m, exp_po_l;
  bit           exp_valid, exp_ovr, exp_err;

  always #5 clk = ~clk;

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .rst_n(rst_n), .S_I(s_i), .S_L(s_l), .P_O(po_m), .P_VALID(pv_m),
    .P_READY(p_ready),
`ifdef SIPO_RX_PARITY_EN
    .P_ERR(perr_m),
`endif
    .OVERRUN(ovr_m));

  sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .S_I(s_i), .S_L(s_l), .P_O(po_l), .P_VALID(pv_l),
    .P_READY(p_ready),
`ifdef SIPO_RX_PARITY_EN
    .P_ERR(perr_l),
`endif
    .OVERRUN(ovr_l));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aligned = 1'b0; wait_par = 1'b0; q.delete();
    exp_po_m = '0; exp_po_l = '0; exp_valid = 1'b0; exp_ovr = 1'b0; exp_err = 1'b0;
  endtask

  // One clock edge of the receiver, expressed as frames of bits.
  task automatic model_step(input bit sl, input bit si, input bit rdy);
    bit complete = 1'b0;
    bit par = 1'b0;
    logic [W-1:0] wm, wl;
    bit x;
    if (!sl) begin
      aligned = 1'b1; wait_par = 1'b0; q.delete();
    end else if (aligned) begin
      if (wait_par) begin
        par = si; complete = 1'b1; aligned = 1'b0; wait_par = 1'b0;
      end else begin
        q.push_back(int'(si));
        if (q.size() == W) begin
`ifdef SIPO_RX_PARITY_EN
          wait_par = 1'b1;
`else
          complete = 1'b1; aligned = 1'b0;
`endif
        end
      end
    end
    exp_ovr = 1'b0;
    if (complete) begin
      wm = '0; wl = '0; x = par;
      for (int i = 0; i < W; i++) begin
        wm[W-1-i] = q[i][0];
        wl[i]     = q[i][0];
        x         = x ^ q[i][0];
      end
      if (!exp_valid || rdy) begin
        exp_po_m = wm; exp_po_l = wl; exp_err = x; exp_valid = 1'b1;
      end else begin
        exp_ovr = 1'b1;
      end
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("po_msb", 32'(po_m), 32'(exp_po_m));
    chk("po_lsb", 32'(po_l), 32'(exp_po_l));
    chk("valid_msb", 32'(pv_m), 32'(exp_valid));
    chk("valid_lsb", 32'(pv_l), 32'(exp_valid));
    chk("ovr_msb", 32'(ovr_m), 32'(exp_ovr));
    chk("ovr_lsb", 32'(ovr_l), 32'(exp_ovr));
`ifdef SIPO_RX_PARITY_EN
    if (exp_valid) begin
      chk("perr_msb", 32'(perr_m), 32'(exp_err));
      chk("perr_lsb", 32'(perr_l), 32'(exp_err));
    end
`endif
  endtask

  task automatic cyc(input bit sl, input bit si, input bit rdy);
    s_l = sl; s_i = si; p_ready = rdy;
    @(posedge clk);
    model_step(sl, si, rdy);
    #1;
    check_all();
  endtask

  // Boundary cycle, then bits b[3] first; parity bit appended when enabled.
  task automatic send_frame(input logic [3:0] b, input bit par, input bit rdy);
    cyc(1'b0, 1'b0, rdy);
    for (int i = 3; i >= 0; i--) cyc(1'b1, b[i], rdy);
`ifdef SIPO_RX_PARITY_EN
    cyc(1'b1, par, rdy);
`else
    if (par) begin end
`endif
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_po", 32'(po_m), 32'd0);
    chk("rst_valid", 32'(pv_m), 32'd0);
    chk("rst_ovr", 32'(ovr_m), 32'd0);
    #10 rst_n = 1'b1;

    // Unaligned shifts after reset are ignored.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0);
    chk("noalign_valid", 32'(pv_m), 32'd0);

    // Basic frame, then a one-edge consume.
    send_frame(4'b0101, 1'b0, 1'b0);
    chk("f0101_msb", 32'(po_m), 32'h5);
    chk("f0101_lsb", 32'(po_l), 32'ha);
    cyc(1'b1, 1'b0, 1'b1);
    chk("consumed", 32'(pv_m), 32'd0);

    // Back-to-back with ready tied high.
    send_frame(4'b0101, 1'b0, 1'b1);
    send_frame(4'b0110, 1'b0, 1'b1);
    chk("b2b_second", 32'(po_m), 32'h6);
    cyc(1'b1, 1'b0, 1'b1);

    // Overrun: second word dropped while first is held.
    send_frame(4'b0101, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0);
    chk("ovr_pulse", 32'(ovr_m), 32'd1);
    chk("ovr_hold", 32'(po_m), 32'h5);
    cyc(1'b1, 1'b0, 1'b1);
    chk("ovr_once", 32'(ovr_m), 32'd0);
    cyc(1'b1, 1'b0, 1'b1);

    // Re-sync discards a partial word.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0);
    chk("resync", 32'(po_m), 32'h6);

    // Asynchronous reset mid-frame and with a word held.
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_po", 32'(po_m), 32'd0);
    chk("arst_valid", 32'(pv_m), 32'd0);
    #2 rst_n = 1'b1;
    send_frame(4'b1011, 1'b1, 1'b0);
    chk("f1011_msb", 32'(po_m), 32'hb);
    chk("f1011_lsb", 32'(po_l), 32'hd);
    cyc(1'b1, 1'b0, 1'b1);

`ifdef SIPO_RX_PARITY_EN
    send_frame(4'b0101, 1'b0, 1'b0);
    chk("par_ok", 32'(perr_m), 32'd0);
    cyc(1'b1, 1'b0, 1'b1);
    send_frame(4'b0101, 1'b1, 1'b0);
    chk("par_err", 32'(perr_m), 32'd1);
    cyc(1'b1, 1'b0, 1'b1);
`endif

    // Random framing, data and ready.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
